// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display scheduler: mode codes,
// FSM state type and the blank pattern.
package seg7_pkg;

    localparam logic [1:0] MODE_TIME = 2'b00;
    localparam logic [1:0] MODE_SET  = 2'b01;
    localparam logic [1:0] MODE_MSG  = 2'b10;

    // Active-low segments: all ones turns every segment off.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_TIME = MODE_TIME,
        ST_SET  = MODE_SET,
        ST_MSG  = MODE_MSG
    } state_t;

endpackage

// File: rtl/seg7_tick_gen.sv
// Free-running modulo-TICK_DIV prescaler; tick is high for the single cycle
// at terminal count. restart forces the count back to zero.
module seg7_tick_gen #(
    parameter int TICK_DIV = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0] cnt_reg;

    assign tick = (cnt_reg == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (restart || tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg7_disp_sched.sv
// Chooses the source for the four seven-segment digits: running time, set-mode
// edit view, or a timed message. Edit-digit blink is built only with SEG7_BLINK_EN.
module seg7_disp_sched #(
    parameter int TICK_DIV   = 500000,
    parameter int MSG_HOLD   = 200,
    parameter int BLINK_HALF = 25
) (
    input  logic        clk_50M,
    input  logic        cr,
    input  logic [27:0] time_seg,
    input  logic        set_active,
    input  logic [27:0] set_seg,
    input  logic [1:0]  set_digit,
    input  logic        msg_req,
    input  logic [27:0] msg_seg,
    output logic [6:0]  Hex0,
    output logic [6:0]  Hex1,
    output logic [6:0]  Hex2,
    output logic [6:0]  Hex3,
    output logic [1:0]  mode,
    output logic        msg_ack,
    output logic        msg_busy
);

    import seg7_pkg::*;

    localparam int HOLD_W = $clog2(MSG_HOLD + 1);

    state_t            state_reg, state_next;
    logic [HOLD_W-1:0] hold_reg;
    logic [27:0]       msg_reg;
    logic [27:0]       hex_reg, hex_next;
    logic              ack_reg, busy_reg;
    logic              tick, restart, accept, expire, blank_phase;

    seg7_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk     (clk_50M),
        .rst     (cr),
        .restart (restart),
        .tick    (tick)
    );

    assign expire = (state_reg == ST_MSG) && tick && (hold_reg == HOLD_W'(MSG_HOLD - 1));

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            ST_TIME: begin
                if (msg_req) begin
                    state_next = ST_MSG;
                    accept     = 1'b1;
                end else if (set_active) begin
                    state_next = ST_SET;
                end
            end
            ST_SET: begin
                if (msg_req) begin
                    state_next = ST_MSG;
                    accept     = 1'b1;
                end else if (!set_active) begin
                    state_next = ST_TIME;
                end
            end
            ST_MSG: begin
                // msg_req is only looked at when the hold period runs out.
                if (expire) begin
                    if (msg_req) begin
                        accept = 1'b1;
                    end else if (set_active) begin
                        state_next = ST_SET;
                    end else begin
                        state_next = ST_TIME;
                    end
                end
            end
            default: state_next = ST_TIME;
        endcase
    end

`ifdef SEG7_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_HALF + 1);

    logic [BLINK_W-1:0] blink_cnt_reg, blink_cnt_next;
    logic               phase_reg, phase_next;
    logic [1:0]         digit_reg;
    logic               blink_restart;

    // Restarting the prescaler with the blink count makes the first visible
    // half-period exactly BLINK_HALF ticks long.
    assign blink_restart = (state_next == ST_SET) &&
                           ((state_reg != ST_SET) || (set_digit != digit_reg));

    always_comb begin
        blink_cnt_next = blink_cnt_reg;
        phase_next     = phase_reg;
        if (blink_restart) begin
            blink_cnt_next = '0;
            phase_next     = 1'b0;
        end else if ((state_reg == ST_SET) && tick) begin
            if (blink_cnt_reg == BLINK_W'(BLINK_HALF - 1)) begin
                blink_cnt_next = '0;
                phase_next     = ~phase_reg;
            end else begin
                blink_cnt_next = blink_cnt_reg + BLINK_W'(1);
            end
        end
    end

    always_ff @(posedge clk_50M or posedge cr) begin
        if (cr) begin
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b0;
            digit_reg     <= 2'd0;
        end else begin
            blink_cnt_reg <= blink_cnt_next;
            phase_reg     <= phase_next;
            digit_reg     <= set_digit;
        end
    end

    assign restart     = accept || blink_restart;
    assign blank_phase = phase_next;
`else
    logic unused_blink_cfg;
    assign unused_blink_cfg = (BLINK_HALF > 0);
    assign restart          = accept;
    assign blank_phase      = 1'b0;
`endif

    // Patterns are computed from the next state so they land with the mode change.
    always_comb begin
        hex_next = {4{SEG_BLANK}};
        for (int i = 0; i < 4; i++) begin
            case (state_next)
                ST_MSG:  hex_next[i*7 +: 7] = accept ? msg_seg[i*7 +: 7] : msg_reg[i*7 +: 7];
                ST_SET:  hex_next[i*7 +: 7] = (blank_phase && (set_digit == 2'(i))) ?
                                              SEG_BLANK : set_seg[i*7 +: 7];
                default: hex_next[i*7 +: 7] = time_seg[i*7 +: 7];
            endcase
        end
    end

    always_ff @(posedge clk_50M or posedge cr) begin
        if (cr) begin
            state_reg <= ST_TIME;
            hold_reg  <= '0;
            msg_reg   <= {4{SEG_BLANK}};
            hex_reg   <= {4{SEG_BLANK}};
            ack_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                msg_reg  <= msg_seg;
                hold_reg <= '0;
            end else if ((state_reg == ST_MSG) && tick) begin
                hold_reg <= hold_reg + HOLD_W'(1);
            end
            hex_reg  <= hex_next;
            ack_reg  <= accept;
            busy_reg <= (state_next == ST_MSG);
        end
    end

    assign Hex0     = hex_reg[6:0];
    assign Hex1     = hex_reg[13:7];
    assign Hex2     = hex_reg[20:14];
    assign Hex3     = hex_reg[27:21];
    assign mode     = state_reg;
    assign msg_ack  = ack_reg;
    assign msg_busy = busy_reg;

endmodule
